mult_datapath: RTL and testbench

Register and arithmetic datapath for the 8-bit signed shift-add multiplier; sits directly downstream of the multiplier control FSM. It consumes the FSM's Clr_ld/Shift/Add/Sub strobes and returns M, the current multiplier LSB. It holds X, A (upper product) and B (multiplier, then lower product), performs 9-bit signed add/subtract of switch operand S into A, and arithmetically shifts X:A:B right. It also drives four active-low 7-segment digits for A and B.

---
 rtl/mult_pkg.sv | 18 +
 rtl/hex_driver.sv | 9 +
 rtl/mult_datapath.sv | 79 +++++++
 tb/tb_mult_datapath.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-add multiplier datapath:
// operand width, control strobe bundle and 7-segment digit table.
package mult_pkg;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic clr_ld;
    logic add;
    logic sub;
    logic shift;
  } strb_t;

  // Active-low segments, bit 0 = a ... bit 6 = g; entry i encodes hex digit i.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/hex_driver.sv
// One nibble to active-low 7-segment decoder.
module hex_driver
  import mult_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[nib];
endmodule

// File: rtl/mult_datapath.sv
// X:A:B register datapath for the 8-bit signed shift-add multiplier,
// with 9-bit add/sub of S into A, fused arithmetic shift and hex readout.
module mult_datapath
  import mult_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr_ld,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Shift,
  input  logic [WIDTH-1:0] S,
  output logic             X,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             M,
  output logic [6:0]       AhexU,
  output logic [6:0]       AhexL,
  output logic [6:0]       BhexU,
  output logic [6:0]       BhexL
);
  localparam int NUM_DIG = 4;

  strb_t            strb;
  logic [WIDTH:0]   r;
  logic             x_n;
  logic [WIDTH-1:0] a_n, b_n;

  assign strb = '{clr_ld: Clr_ld, add: Add, sub: Sub, shift: Shift};

  always_comb begin
    x_n = X;
    a_n = Aval;
    b_n = Bval;
    // Sub takes priority when both arithmetic strobes are high.
    if (strb.sub) r = {Aval[WIDTH-1], Aval} + ~{S[WIDTH-1], S} + 9'd1;
    else          r = {Aval[WIDTH-1], Aval} + {S[WIDTH-1], S};
    if (strb.clr_ld) begin
      x_n = 1'b0;
      a_n = '0;
      b_n = S;
    end else if (strb.add || strb.sub) begin
      x_n = r[WIDTH];
      if (strb.shift) begin
        a_n = r[WIDTH:1];
        b_n = {r[0], Bval[WIDTH-1:1]};
      end else begin
        a_n = r[WIDTH-1:0];
      end
    end else if (strb.shift) begin
      a_n = {X, Aval[WIDTH-1:1]};
      b_n = {Aval[0], Bval[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      X    <= 1'b0;
      Aval <= '0;
      Bval <= '0;
    end else begin
      X    <= x_n;
      Aval <= a_n;
      Bval <= b_n;
    end
  end

  assign M = Bval[0];

  logic [NUM_DIG-1:0][3:0] nib;
  logic [NUM_DIG-1:0][6:0] seg;

  assign nib = {Aval[7:4], Aval[3:0], Bval[7:4], Bval[3:0]};
  assign {AhexU, AhexL, BhexU, BhexL} = seg;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_hex
    hex_driver u_hex (.nib(nib[i]), .seg(seg[i]));
  end
endmodule

// File: tb/tb_mult_datapath.sv
// Directed-vector bench for mult_datapath with hand-computed expectations.
module tb_mult_datapath;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Clr_ld = 1'b0, Add = 1'b0, Sub = 1'b0, Shift = 1'b0;
  logic [7:0] S = 8'h00;
  logic       X, M;
  logic [7:0] Aval, Bval;
  logic [6:0] AhexU, AhexL, BhexU, BhexL;

  int n_tests = 0;
  int n_fail  = 0;

  mult_datapath dut (
    .Clk(Clk), .Reset(Reset), .Clr_ld(Clr_ld), .Add(Add), .Sub(Sub),
    .Shift(Shift), .S(S), .X(X), .Aval(Aval), .Bval(Bval), .M(M),
    .AhexU(AhexU), .AhexL(AhexL), .BhexU(BhexU), .BhexL(BhexL)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes, sample 1ns after the edge, then release.
  task automatic step(input logic c, input logic a, input logic su,
                      input logic sh, input logic [7:0] s);
    Clr_ld = c; Add = a; Sub = su; Shift = sh; S = s;
    @(posedge Clk); #1;
    Clr_ld = 0; Add = 0; Sub = 0; Shift = 0;
  endtask

  task automatic check_xab(input string tag, input logic x, input logic [7:0] a,
                           input logic [7:0] b);
    check({tag, ".X"}, {15'd0, X}, {15'd0, x});
    check({tag, ".A"}, {8'd0, Aval}, {8'd0, a});
    check({tag, ".B"}, {8'd0, Bval}, {8'd0, b});
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("rst.XAB", {7'd0, X, Aval}, 16'h0000);
    @(negedge Clk); Reset = 0;

    // Build X=1, A=0x3C, B=0x81 then reset asynchronously mid-cycle.
    step(1, 0, 0, 0, 8'h81);
    step(0, 1, 0, 0, 8'h80);
    step(0, 1, 0, 0, 8'hBC);
    check_xab("pre_rst", 1'b1, 8'h3C, 8'h81);
    check("pre_rst.M", {15'd0, M}, 16'd1);
    #2 Reset = 1;
    #1;
    check_xab("async_rst", 1'b0, 8'h00, 8'h00);
    check("async_rst.M", {15'd0, M}, 16'd0);
    check("async_rst.hexA", {2'b0, AhexU, AhexL}, {2'b0, 7'b1000000, 7'b1000000});
    check("async_rst.hexB", {2'b0, BhexU, BhexL}, {2'b0, 7'b1000000, 7'b1000000});
    Add = 1; Clr_ld = 1; S = 8'h55;
    @(posedge Clk); #1;
    check_xab("rst_hold", 1'b0, 8'h00, 8'h00);
    @(negedge Clk); Reset = 0; Add = 0; Clr_ld = 0;

    // Clr_ld beats Add.
    step(0, 1, 0, 0, 8'h80);
    step(0, 1, 0, 0, 8'h92);
    check_xab("pre_clr", 1'b1, 8'h12, 8'h00);
    step(1, 1, 0, 0, 8'h05);
    check_xab("clr_ld", 1'b0, 8'h00, 8'h05);
    check("clr_ld.M", {15'd0, M}, 16'd1);

    // Add then Shift.
    step(0, 1, 0, 0, 8'hFE);
    check_xab("add", 1'b1, 8'hFE, 8'h05);
    step(0, 0, 0, 1, 8'h00);
    check_xab("shift", 1'b1, 8'hFF, 8'h02);
    check("shift.M", {15'd0, M}, 16'd0);
    check("shift.BhexL", {9'd0, BhexL}, {9'd0, 7'h24});
    step(0, 0, 0, 0, 8'h33);
    check_xab("hold", 1'b1, 8'hFF, 8'h02);

    // Sub, and Sub winning over Add.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h03);
    step(0, 0, 1, 0, 8'h05);
    check_xab("sub", 1'b1, 8'hFE, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h03);
    step(0, 1, 1, 0, 8'h05);
    check_xab("add_sub", 1'b1, 8'hFE, 8'h00);

    // Fused Sub+Shift and Add+Shift.
    step(1, 0, 0, 0, 8'h80);
    step(0, 0, 1, 1, 8'h01);
    check_xab("sub_shift", 1'b1, 8'hFF, 8'hC0);
    step(1, 0, 0, 0, 8'h01);
    step(0, 1, 0, 1, 8'h03);
    check_xab("add_shift", 1'b0, 8'h01, 8'h80);

    // Shift-only pulls X into A[7].
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h01);
    step(0, 0, 0, 1, 8'h00);
    check_xab("shift_x", 1'b1, 8'hFF, 8'h80);

    // Full multiply 7 * -3.
    step(1, 0, 0, 0, 8'hFD);
    for (int i = 0; i < 7; i++) begin
      if (M) step(0, 1, 0, 0, 8'h07);
      step(0, 0, 0, 1, 8'h07);
    end
    if (M) step(0, 0, 1, 0, 8'h07);
    step(0, 0, 0, 1, 8'h07);
    check("mul.AB", {Aval, Bval}, 16'hFFEB);
    check("mul.M", {15'd0, M}, 16'd1);
    check("mul.hexA", {2'b0, AhexU, AhexL}, {2'b0, 7'h0E, 7'h0E});
    check("mul.hexB", {2'b0, BhexU, BhexL}, {2'b0, 7'h06, 7'h03});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
